// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback for the multi-cycle datapath
module multicycle_control #(
  parameter int OPW = 6,
  parameter int FNW = 6,
  parameter int HAS_EXT = 1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [FNW-1:0]  funct,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_ovf,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic [3:0]      state,
  output logic            v_flag,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXEC,
    S_R_WB, S_BRANCH, S_I_EXEC, S_I_WB, S_LINK, S_JREG, S_LINK_WB
  } state_t;

  localparam logic [OPW-1:0] OP_R      = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW     = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW     = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ    = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BLEZAL = OPW'(6'b100100);
  localparam logic [OPW-1:0] OP_BALV   = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_NANDI  = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_JALPC  = OPW'(6'b011111);
  localparam logic [FNW-1:0] FN_BRV    = FNW'(6'b010100);

  state_t        r_state, w_next;
  logic          r_v;
  logic [CNTW-1:0] r_ret;
  logic w_ext, w_rt, w_lw, w_sw, w_beq, w_blezal, w_balv, w_nandi, w_jalpc, w_brv;
  logic w_take, w_retire;
  logic w_fetch, w_decode, w_maddr, w_mrd, w_mwb, w_mwr, w_rexec, w_rwb;
  logic w_branch, w_iexec, w_iwb, w_link, w_jreg, w_lwb;

  assign w_ext    = HAS_EXT != 0;
  assign w_rt     = opcode == OP_R;
  assign w_lw     = opcode == OP_LW;
  assign w_sw     = opcode == OP_SW;
  assign w_beq    = opcode == OP_BEQ;
  assign w_blezal = w_ext && opcode == OP_BLEZAL;
  assign w_balv   = w_ext && opcode == OP_BALV;
  assign w_nandi  = w_ext && opcode == OP_NANDI;
  assign w_jalpc  = w_ext && opcode == OP_JALPC;
  assign w_brv    = w_ext && funct == FN_BRV;

  assign w_fetch  = r_state == S_FETCH;
  assign w_decode = r_state == S_DECODE;
  assign w_maddr  = r_state == S_MEM_ADDR;
  assign w_mrd    = r_state == S_MEM_RD;
  assign w_mwb    = r_state == S_MEM_WB;
  assign w_mwr    = r_state == S_MEM_WR;
  assign w_rexec  = r_state == S_R_EXEC;
  assign w_rwb    = r_state == S_R_WB;
  assign w_branch = r_state == S_BRANCH;
  assign w_iexec  = r_state == S_I_EXEC;
  assign w_iwb    = r_state == S_I_WB;
  assign w_link   = r_state == S_LINK;
  assign w_jreg   = r_state == S_JREG;
  assign w_lwb    = r_state == S_LINK_WB;

  // balv reads the sticky flag, never the live ALU flags
  assign w_take = w_beq ? alu_zero : w_blezal ? (alu_zero | alu_neg) : (w_balv & r_v);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = w_rt ? S_R_EXEC : (w_lw | w_sw) ? S_MEM_ADDR :
                           (w_beq | w_blezal | w_balv) ? S_BRANCH :
                           w_nandi ? S_I_EXEC : w_jalpc ? S_LINK : S_FETCH;
      S_MEM_ADDR: w_next = w_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = w_brv ? S_JREG : S_R_WB;
      S_BRANCH:   w_next = ((w_blezal | w_balv) & w_take) ? S_LINK_WB : S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_LINK:     w_next = S_JREG;
      default:    w_next = S_FETCH;
    endcase
  end

  assign w_retire = w_next == S_FETCH && !w_fetch && !w_decode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_v     <= 1'b0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      r_v     <= w_rexec ? (r_v | alu_ovf) : (w_jreg & w_rt) ? 1'b0 : r_v;
      r_ret   <= w_retire ? r_ret + CNTW'(1) : r_ret;
    end
  end

  // JREG serves brv (opcode 0, conditional on the flag) and jalpc (unconditional)
  assign pc_write   = !reset & ((w_fetch & mem_ready) | (w_branch & w_take) | (w_jreg & (w_rt ? r_v : 1'b1)));
  assign ir_write   = !reset & w_fetch & mem_ready;
  assign iord       = !reset & (w_mrd | w_mwr);
  assign mem_read   = !reset & (w_fetch | w_mrd);
  assign mem_write  = !reset & w_mwr;
  assign reg_write  = !reset & (w_mwb | w_rwb | w_iwb | w_link | w_lwb);
  assign reg_dst    = (w_link | w_lwb) ? 2'b10 : w_rwb ? 2'b01 : 2'b00;
  assign mem_to_reg = (w_link | w_lwb) ? 2'b10 : w_mwb ? 2'b01 : 2'b00;
  assign alu_src_a  = w_maddr | w_rexec | w_branch | w_iexec;
  assign alu_src_b  = w_fetch ? 2'b01 : w_decode ? 2'b11 : (w_maddr | w_iexec) ? 2'b10 : 2'b00;
  assign alu_op     = w_rexec ? 2'b10 : w_branch ? 2'b01 : w_iexec ? 2'b11 : 2'b00;
  assign pc_src     = w_branch ? 2'b01 : w_jreg ? 2'b11 : 2'b00;
  assign illegal    = !reset & ((w_decode & w_next == S_FETCH) | r_state >= 4'd14);
  assign state      = r_state;
  assign v_flag     = r_v;
  assign retired    = r_ret;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table + scoreboard for the main build, hand sequences for HAS_EXT=0/CNTW=4
module tb_multicycle_control;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, alu_zero = 1'b0, alu_neg = 1'b0, alu_ovf = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;

  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a, v_flag, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [15:0] retired;

  logic a_pc_write, a_ir_write, a_iord, a_mem_read, a_mem_write, a_reg_write, a_alu_src_a, a_v_flag, a_illegal;
  logic [1:0] a_reg_dst, a_mem_to_reg, a_alu_src_b, a_alu_op, a_pc_src;
  logic [3:0] a_state, a_retired;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_ovf(alu_ovf), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state), .v_flag(v_flag), .illegal(illegal), .retired(retired)
  );

  multicycle_control #(.HAS_EXT(0), .CNTW(4)) alt (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_ovf(alu_ovf), .mem_ready(mem_ready), .pc_write(a_pc_write), .ir_write(a_ir_write), .iord(a_iord),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .pc_src(a_pc_src), .state(a_state), .v_flag(a_v_flag), .illegal(a_illegal), .retired(a_retired)
  );

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BLEZAL = 6'b100100, BALV = 6'b100000, NANDI = 6'b010000, JALPC = 6'b011111;
  localparam logic [5:0] BAD = 6'b111111, ADD = 6'b100000, BRV = 6'b010100;
  // {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  localparam logic [10:0] MF = 11'b00_00_0_01_00_00, MD = 11'b00_00_0_11_00_00, MA = 11'b00_00_1_10_00_00;
  localparam logic [10:0] MZ = 11'b0, MMW = 11'b00_01_0_00_00_00, MRE = 11'b00_00_1_00_10_00;
  localparam logic [10:0] MRW = 11'b01_00_0_00_00_00, MB = 11'b00_00_1_00_01_01, MIE = 11'b00_00_1_10_11_00;
  localparam logic [10:0] ML = 11'b10_10_0_00_00_00, MJ = 11'b00_00_0_00_00_11;
  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write}
  localparam logic [5:0] E0 = 6'b000000, EF = 6'b000100, EFR = 6'b110100, EMR = 6'b001100;
  localparam logic [5:0] EMW = 6'b001010, ERW = 6'b000001, EPC = 6'b100000;

  typedef struct {
    int id;
    logic r;
    logic [5:0] op, fn;
    logic [2:0] zno;
    logic rdy;
    logic [3:0] st;
    logic [5:0] en;
    logic [10:0] mx;
    logic vf, il;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int errors = 0, checks = 0;

  function automatic vec_t mk(logic r, logic [5:0] op, logic [5:0] fn, logic [2:0] zno, logic rdy,
                              logic [3:0] st, logic [5:0] en, logic [10:0] mx, logic vf, logic il, int ret);
    vec_t v;
    v.id = 0; v.r = r; v.op = op; v.fn = fn; v.zno = zno; v.rdy = rdy;
    v.st = st; v.en = en; v.mx = mx; v.vf = vf; v.il = il; v.ret = ret[15:0];
    return v;
  endfunction

  task automatic drv(logic r, logic [5:0] op, logic [5:0] fn, logic [2:0] zno, logic rdy);
    @(posedge clk);
    #1;
    reset = r; opcode = op; funct = fn; {alu_zero, alu_neg, alu_ovf} = zno; mem_ready = rdy;
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [5:0] en_a;
      logic [10:0] mx_a;
      e = sb.pop_front();
      en_a = {pc_write, ir_write, iord, mem_read, mem_write, reg_write};
      mx_a = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};
      checks++;
      if ({state, en_a, mx_a, v_flag, illegal, retired} !== {e.st, e.en, e.mx, e.vf, e.il, e.ret}) begin
        errors++;
        $display("FAIL vec%0d: got st=%0d en=%b mx=%b v=%b il=%b ret=%0d want st=%0d en=%b mx=%b v=%b il=%b ret=%0d",
                 e.id, state, en_a, mx_a, v_flag, illegal, retired, e.st, e.en, e.mx, e.vf, e.il, e.ret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset, then lw with two-cycle waits in FETCH and MEM_RD
    tbl.push_back(mk(1, LW, 0, 0, 0, 0, E0, MF, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, EF, MF, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, EF, MF, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 1, 0, EFR, MF, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 1, E0, MD, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 2, E0, MA, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 3, EMR, MZ, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 3, EMR, MZ, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 1, 3, EMR, MZ, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 0, 0, 4, ERW, MMW, 0, 0, 0));
    // second lw abandoned by a 3-cycle reset in MEM_RD
    tbl.push_back(mk(0, LW, 0, 0, 1, 0, EFR, MF, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 0, 1, E0, MD, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 0, 2, E0, MA, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 0, 3, EMR, MZ, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 0, 0, 3, E0, MZ, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 0, 0, 0, E0, MF, 0, 0, 0));
    tbl.push_back(mk(1, LW, 0, 0, 0, 0, E0, MF, 0, 0, 0));
    // add with overflow, then brv taken on the sticky flag
    tbl.push_back(mk(0, RT, ADD, 0, 0, 0, EF, MF, 0, 0, 0));
    tbl.push_back(mk(0, RT, ADD, 0, 1, 0, EFR, MF, 0, 0, 0));
    tbl.push_back(mk(0, RT, ADD, 0, 0, 1, E0, MD, 0, 0, 0));
    tbl.push_back(mk(0, RT, ADD, 3'b001, 0, 6, E0, MRE, 0, 0, 0));
    tbl.push_back(mk(0, RT, ADD, 0, 0, 7, ERW, MRW, 1, 0, 0));
    tbl.push_back(mk(0, RT, BRV, 0, 1, 0, EFR, MF, 1, 0, 1));
    tbl.push_back(mk(0, RT, BRV, 0, 0, 1, E0, MD, 1, 0, 1));
    tbl.push_back(mk(0, RT, BRV, 0, 0, 6, E0, MRE, 1, 0, 1));
    tbl.push_back(mk(0, RT, BRV, 0, 0, 12, EPC, MJ, 1, 0, 1));
    // brv with overflow in its own R_EXEC: set wins, branch taken
    tbl.push_back(mk(0, RT, BRV, 0, 1, 0, EFR, MF, 0, 0, 2));
    tbl.push_back(mk(0, RT, BRV, 0, 0, 1, E0, MD, 0, 0, 2));
    tbl.push_back(mk(0, RT, BRV, 3'b001, 0, 6, E0, MRE, 0, 0, 2));
    tbl.push_back(mk(0, RT, BRV, 0, 0, 12, EPC, MJ, 1, 0, 2));
    // blezal taken (neg) with link, then not taken
    tbl.push_back(mk(0, BLEZAL, 0, 0, 1, 0, EFR, MF, 0, 0, 3));
    tbl.push_back(mk(0, BLEZAL, 0, 0, 0, 1, E0, MD, 0, 0, 3));
    tbl.push_back(mk(0, BLEZAL, 0, 3'b010, 0, 8, EPC, MB, 0, 0, 3));
    tbl.push_back(mk(0, BLEZAL, 0, 0, 0, 13, ERW, ML, 0, 0, 3));
    tbl.push_back(mk(0, BLEZAL, 0, 0, 1, 0, EFR, MF, 0, 0, 4));
    tbl.push_back(mk(0, BLEZAL, 0, 0, 0, 1, E0, MD, 0, 0, 4));
    tbl.push_back(mk(0, BLEZAL, 0, 3'b000, 0, 8, E0, MB, 0, 0, 4));
    // balv with v=0 ignores live zero/neg
    tbl.push_back(mk(0, BALV, 0, 0, 1, 0, EFR, MF, 0, 0, 5));
    tbl.push_back(mk(0, BALV, 0, 0, 0, 1, E0, MD, 0, 0, 5));
    tbl.push_back(mk(0, BALV, 0, 3'b110, 0, 8, E0, MB, 0, 0, 5));
    // beq taken
    tbl.push_back(mk(0, BEQ, 0, 0, 1, 0, EFR, MF, 0, 0, 6));
    tbl.push_back(mk(0, BEQ, 0, 0, 0, 1, E0, MD, 0, 0, 6));
    tbl.push_back(mk(0, BEQ, 0, 3'b100, 0, 8, EPC, MB, 0, 0, 6));
    // sw with ready on first MEM_WR cycle
    tbl.push_back(mk(0, SW, 0, 0, 1, 0, EFR, MF, 0, 0, 7));
    tbl.push_back(mk(0, SW, 0, 0, 0, 1, E0, MD, 0, 0, 7));
    tbl.push_back(mk(0, SW, 0, 0, 0, 2, E0, MA, 0, 0, 7));
    tbl.push_back(mk(0, SW, 0, 0, 1, 5, EMW, MZ, 0, 0, 7));
    // jalpc
    tbl.push_back(mk(0, JALPC, 0, 0, 1, 0, EFR, MF, 0, 0, 8));
    tbl.push_back(mk(0, JALPC, 0, 0, 0, 1, E0, MD, 0, 0, 8));
    tbl.push_back(mk(0, JALPC, 0, 0, 0, 11, ERW, ML, 0, 0, 8));
    tbl.push_back(mk(0, JALPC, 0, 0, 0, 12, EPC, MJ, 0, 0, 8));
    // nandi
    tbl.push_back(mk(0, NANDI, 0, 0, 1, 0, EFR, MF, 0, 0, 9));
    tbl.push_back(mk(0, NANDI, 0, 0, 0, 1, E0, MD, 0, 0, 9));
    tbl.push_back(mk(0, NANDI, 0, 0, 0, 9, E0, MIE, 0, 0, 9));
    tbl.push_back(mk(0, NANDI, 0, 0, 0, 10, ERW, MZ, 0, 0, 9));
    // unknown opcode: one-cycle illegal, no retire
    tbl.push_back(mk(0, BAD, 0, 0, 1, 0, EFR, MF, 0, 0, 10));
    tbl.push_back(mk(0, BAD, 0, 0, 0, 1, E0, MD, 0, 1, 10));
    tbl.push_back(mk(0, RT, ADD, 0, 0, 0, EF, MF, 0, 0, 10));
    // set v, then balv taken with link
    tbl.push_back(mk(0, RT, ADD, 0, 1, 0, EFR, MF, 0, 0, 10));
    tbl.push_back(mk(0, RT, ADD, 0, 0, 1, E0, MD, 0, 0, 10));
    tbl.push_back(mk(0, RT, ADD, 3'b001, 0, 6, E0, MRE, 0, 0, 10));
    tbl.push_back(mk(0, RT, ADD, 0, 0, 7, ERW, MRW, 1, 0, 10));
    tbl.push_back(mk(0, BALV, 0, 0, 1, 0, EFR, MF, 1, 0, 11));
    tbl.push_back(mk(0, BALV, 0, 0, 0, 1, E0, MD, 1, 0, 11));
    tbl.push_back(mk(0, BALV, 0, 3'b000, 0, 8, EPC, MB, 1, 0, 11));
    tbl.push_back(mk(0, BALV, 0, 0, 0, 13, ERW, ML, 1, 0, 11));
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, EF, MF, 1, 0, 12));

    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      v.id = i;
      drv(v.r, v.op, v.fn, v.zno, v.rdy);
      sb.push_back(v);
    end
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);

    // CNTW=4 counter wrap over 16 R-types
    drv(1, RT, ADD, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drv(0, RT, ADD, 0, 1);
      chk("alt_ret", a_retired, i % 16);
      chk("alt_fetch", a_state, 0);
      drv(0, RT, ADD, 0, 0);
      drv(0, RT, ADD, 0, 0);
      drv(0, RT, ADD, 0, 0);
    end
    drv(0, RT, ADD, 0, 0);
    chk("alt_ret_wrap", a_retired, 0);
    chk("main_ret_16", retired, 16);

    // HAS_EXT=0: nandi is illegal in DECODE, no retire
    drv(0, NANDI, 0, 0, 1);
    drv(0, NANDI, 0, 0, 0);
    chk("alt_nandi_decode", a_state, 1);
    chk("alt_nandi_ill", a_illegal, 1);
    chk("main_nandi_ill", illegal, 0);
    drv(0, NANDI, 0, 0, 0);
    chk("alt_nandi_back", a_state, 0);
    chk("alt_nandi_ill_off", a_illegal, 0);
    chk("alt_nandi_ret", a_retired, 0);
    chk("main_nandi_iexec", state, 9);

    // HAS_EXT=0: brv funct is an ordinary R-type
    drv(1, RT, BRV, 0, 0);
    drv(0, RT, BRV, 0, 1);
    drv(0, RT, BRV, 0, 0);
    drv(0, RT, BRV, 0, 0);
    chk("alt_brv_rexec", a_state, 6);
    drv(0, RT, BRV, 0, 0);
    chk("alt_brv_rwb", a_state, 7);
    chk("main_brv_jreg", state, 12);

    // unknown opcode on the HAS_EXT=0 build
    drv(1, BAD, 0, 0, 0);
    drv(0, BAD, 0, 0, 1);
    drv(0, BAD, 0, 0, 0);
    chk("alt_bad_ill", a_illegal, 1);
    drv(0, BAD, 0, 0, 0);
    chk("alt_bad_ill_off", a_illegal, 0);
    chk("alt_bad_fetch", a_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
